jtag_tap_bscan: RTL and testbench

- Parametrised IEEE 1149.1-style TAP controller with an integrated boundary-scan register (BSR) of NUM_IN input cells and NUM_OUT output cells.
- Sits between the chip pins (parallel_in/parallel_out) and the core (core_in/core_out). Adds a 16-state TAP FSM, an IR_LEN-bit instruction register, IDCODE, BYPASS, SAMPLE/PRELOAD, EXTEST and INTEST.
- Also provides a 32-bit TDO history register for bench checking.

---
 rtl/jtag_tap_bscan.sv | 147 ++++++++++++++
 tb/tb_jtag_tap_bscan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_bscan.sv
// IEEE 1149.1-style TAP controller with an integrated boundary-scan register between pins and core.
// TDO is combinational from the selected shift register; pins are driven only from the update latch.
module jtag_tap_bscan #(
    parameter int          NUM_IN     = 9,
    parameter int          NUM_OUT    = 5,
    parameter int          IR_LEN     = 5,
    parameter logic [31:0] IDCODE_VAL = 32'h1A5B_C0DF
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TMS,
    input  logic               TDI,
    output logic               TDO,
    input  logic [NUM_IN-1:0]  parallel_in,
    output logic [NUM_IN-1:0]  core_in,
    input  logic [NUM_OUT-1:0] core_out,
    output logic [NUM_OUT-1:0] parallel_out,
    output logic [31:0]        sr_parallel_out,
    output logic [IR_LEN-1:0]  instruction,
    output logic [3:0]         tap_state
);

    localparam int BSR_LEN = NUM_IN + NUM_OUT;

    localparam logic [IR_LEN-1:0] I_EXTEST = IR_LEN'(0);
    localparam logic [IR_LEN-1:0] I_IDCODE = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] I_SAMPLE = IR_LEN'(2);
    localparam logic [IR_LEN-1:0] I_INTEST = IR_LEN'(3);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

    state_t              state;
    state_t              nxt;
    logic [IR_LEN-1:0]   ir_sr;
    logic [IR_LEN-1:0]   instr;
    logic [31:0]         id_sr;
    logic                byp_sr;
    logic [BSR_LEN-1:0]  bsr_sr;
    logic [BSR_LEN-1:0]  upd;
    logic [31:0]         hist;
    logic                sel_bsr;
    logic                sel_id;
    logic                dr_lsb;
    logic [NUM_IN-1:0]   update_in;
    logic [NUM_OUT-1:0]  update_out;

    function automatic state_t next_state(input state_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PAU_DR;
            PAU_DR:  return tms ? EX2_DR : PAU_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PAU_IR;
            PAU_IR:  return tms ? EX2_IR : PAU_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            default: return tms ? SEL_DR : RTI;
        endcase
    endfunction

    assign nxt = next_state(state, TMS);

    // Unlisted codes fall through to BYPASS.
    assign sel_bsr = (instr == I_EXTEST) || (instr == I_SAMPLE) || (instr == I_INTEST);
    assign sel_id  = (instr == I_IDCODE);
    assign dr_lsb  = sel_bsr ? bsr_sr[0] : (sel_id ? id_sr[0] : byp_sr);

    always_comb begin
        TDO = 1'b0;
        if (state == SH_IR)
            TDO = ir_sr[0];
        else if (state == SH_DR)
            TDO = dr_lsb;
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state  <= TLR;
            instr  <= I_IDCODE;
            upd    <= '0;
            hist   <= '0;
            ir_sr  <= '0;
            id_sr  <= '0;
            byp_sr <= 1'b0;
            bsr_sr <= '0;
        end else begin
            state <= nxt;
            case (state)
                CAP_IR: ir_sr <= IR_LEN'(1);
                SH_IR:  ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
                UPD_IR: instr <= ir_sr;
                CAP_DR: begin
                    if (sel_bsr)
                        bsr_sr <= (instr == I_INTEST) ? {core_out, update_in} : {core_out, parallel_in};
                    else if (sel_id)
                        id_sr <= IDCODE_VAL;
                    else
                        byp_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_bsr)
                        bsr_sr <= {TDI, bsr_sr[BSR_LEN-1:1]};
                    else if (sel_id)
                        id_sr <= {TDI, id_sr[31:1]};
                    else
                        byp_sr <= TDI;
                end
                UPD_DR: if (sel_bsr) upd <= bsr_sr;
                default: ;
            endcase
            if (state == SH_DR || state == SH_IR)
                hist <= {TDO, hist[31:1]};
            // TMS-driven entry to TLR acts as a soft reset of the instruction and pins.
            if (nxt == TLR) begin
                instr <= I_IDCODE;
                upd   <= '0;
            end
        end
    end

    assign update_in  = upd[NUM_IN-1:0];
    assign update_out = upd[BSR_LEN-1:NUM_IN];

    always_comb begin
        parallel_out = core_out;
        core_in      = parallel_in;
        if (instr == I_EXTEST)
            parallel_out = update_out;
        else if (instr == I_INTEST)
            core_in = update_in;
    end

    assign sr_parallel_out = hist;
    assign instruction     = instr;
    assign tap_state       = state;

endmodule

// File: tb/tb_jtag_tap_bscan.sv
// Directed bench for jtag_tap_bscan: expected TDO bits are queued as stimulus is driven and popped as they appear.
module tb_jtag_tap_bscan;

    logic        TCK = 1'b0;
    logic        TRST, TMS, TDI, TDO;
    logic [8:0]  parallel_in, core_in;
    logic [4:0]  core_out, parallel_out;
    logic [31:0] sr_parallel_out;
    logic [4:0]  instruction;
    logic [3:0]  tap_state;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    jtag_tap_bscan #(.NUM_IN(9), .NUM_OUT(5), .IR_LEN(5), .IDCODE_VAL(32'h1A5B_C0DF)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .parallel_in(parallel_in), .core_in(core_in),
        .core_out(core_out), .parallel_out(parallel_out),
        .sr_parallel_out(sr_parallel_out), .instruction(instruction), .tap_state(tap_state)
    );

    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic tms);
        TMS = tms;
        @(posedge TCK);
        #1;
    endtask

    // Shift n bits from SH_DR/SH_IR; optionally leave to EX1 on the last bit.
    task automatic shift(input string tag, input int n, input logic [31:0] din,
                         input logic [31:0] exp, input bit leave);
        logic e;
        for (int i = 0; i < n; i++) begin
            TMS = leave && (i == n - 1);
            TDI = din[i];
            exp_q.push_back(exp[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s_tdo%0d", tag, i), {31'b0, TDO}, {31'b0, e});
            @(posedge TCK);
            #1;
        end
        TDI = 1'b0;
    endtask

    task automatic to_shdr();
        tick(1); tick(0); tick(0);
    endtask

    task automatic to_shir();
        tick(1); tick(1); tick(0); tick(0);
    endtask

    task automatic upd_idle();
        tick(1); tick(0);
    endtask

    task automatic load_ir(input logic [4:0] code);
        to_shir();
        shift($sformatf("ir%0h", code), 5, {27'b0, code}, 32'h1, 1'b1);
        upd_idle();
    endtask

    initial begin
        TRST = 1'b1; TMS = 1'b0; TDI = 1'b0;
        parallel_in = 9'h1A5; core_out = 5'h0A;
        tick(0);
        TRST = 1'b0;
        chk("rst_state", tap_state, 4'h0);
        chk("rst_instr", instruction, 5'h01);
        chk("rst_hist", sr_parallel_out, 32'h0);
        chk("rst_pout", parallel_out, 5'h0A);
        chk("rst_cin", core_in, 9'h1A5);

        // IDCODE readout straight after reset
        tick(0);
        chk("rti_tdo", {31'b0, TDO}, 32'h0);
        to_shdr();
        chk("shdr_state", tap_state, 4'h4);
        shift("idcode", 32, 32'h0, 32'h1A5B_C0DF, 1'b1);
        chk("idcode_hist", sr_parallel_out, 32'h1A5B_C0DF);
        upd_idle();
        chk("idcode_instr", instruction, 5'h01);

        // IR capture pattern and EXTEST with a cleared update latch
        load_ir(5'h00);
        chk("extest_instr", instruction, 5'h00);
        chk("extest0_pout", parallel_out, 5'h00);
        chk("extest0_cin", core_in, 9'h1A5);

        // BYPASS: one-cycle delay with leading 0
        load_ir(5'h1F);
        chk("byp_instr", instruction, 5'h1F);
        to_shdr();
        shift("byp", 4, 32'hD, 32'hA, 1'b1);
        upd_idle();

        // TMS=1 x5 from PAU_IR
        tick(1); tick(1); tick(0); tick(1); tick(0);
        chk("pauir_state", tap_state, 4'hD);
        for (int i = 0; i < 5; i++) tick(1);
        chk("tmsrst_state", tap_state, 4'h0);
        chk("tmsrst_instr", instruction, 5'h01);
        tick(0);

        // SAMPLE/PRELOAD capture plus output-cell preload
        load_ir(5'h02);
        to_shdr();
        shift("sample", 14, 32'h2A00, 32'h15A5, 1'b1);
        chk("sample_hist", sr_parallel_out[31:18], 32'h15A5);
        chk("ex1dr_state", tap_state, 4'h5);
        upd_idle();
        chk("sample_pout", parallel_out, 5'h0A);

        load_ir(5'h00);
        chk("extest_pout", parallel_out, 5'h15);
        chk("extest_cin", core_in, 9'h1A5);
        core_out = 5'h03;
        #1;
        chk("extest_pout_hold", parallel_out, 5'h15);

        // Abort a shift with TRST
        to_shdr();
        shift("ext_mid", 3, 32'h7, 32'h5, 1'b0);
        chk("mid_state", tap_state, 4'h4);
        chk("mid_pout", parallel_out, 5'h15);
        TRST = 1'b1;
        tick(0);
        TRST = 1'b0;
        chk("abort_state", tap_state, 4'h0);
        chk("abort_instr", instruction, 5'h01);
        chk("abort_pout", parallel_out, 5'h03);
        chk("abort_hist", sr_parallel_out, 32'h0);

        // INTEST drives the core from the update latch
        tick(0);
        load_ir(5'h02);
        to_shdr();
        shift("pre_in", 14, 32'h00C3, 32'h07A5, 1'b1);
        upd_idle();
        load_ir(5'h03);
        chk("intest_cin", core_in, 9'h0C3);
        chk("intest_pout", parallel_out, 5'h03);
        to_shdr();
        shift("intest", 14, 32'h00C3, 32'h06C3, 1'b1);
        upd_idle();
        chk("intest_cin2", core_in, 9'h0C3);

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
